uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter BAUD_W, default 19, width of the bit-time divisor.
REQ-002 Parameter FRAME_BITS, default 11, serial bits per frame (fixed).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  one-cycle write strobe from processor; requests a frame.
REQ-006 data  input  8  byte to send; sampled only in the cycle load is accepted.
REQ-007 baud_k  input  BAUD_W  clock cycles per bit; 0 treated as 1.
REQ-008 eight  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-009 pen  input  1  1 = parity bit present.
REQ-010 ohel  input  1  parity sense: 1 = odd, 0 = even.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 tx_done  output  1  one-cycle pulse at frame end; drives TX ready flop "set".
REQ-013 busy  output  1  high from accepted load until frame end.

Function
REQ-014 States SHALL be IDLE and SHIFT only.
REQ-015 In IDLE, load=1 SHALL latch frame, baud_k, eight, pen, ohel and move to SHIFT next edge; busy=1 from that edge.
REQ-016 tx SHALL go low (start bit) on the same edge load is accepted (latency 1 cycle).
REQ-017 Frame, LSB first: bit0 start=0; bits1-7 = data[0..6]; bit8 = eight ? data[7] : (pen ? P : 1); bit9 = eight ? (pen ? P : 1) : 1; bit10 = 1.
REQ-018 P SHALL be XOR of the 7 or 8 active data bits when ohel=0, its inverse when ohel=1.
REQ-019 Each bit SHALL be held on tx for exactly max(baud_k,1) clock cycles; bit-time counter counts 0..k-1, then wraps and bit counter increments.
REQ-020 After bit10 completes (bit counter reaches FRAME_BITS), the engine SHALL return to IDLE with tx=1, busy=0, and assert tx_done for exactly one cycle on that edge.
REQ-021 load while busy=1 SHALL be ignored; no queued request, no frame corruption.
REQ-022 load in the same cycle tx_done is high SHALL be accepted (back-to-back frames, no idle gap beyond one cycle).
REQ-023 Changes on baud_k, eight, pen, ohel, data during SHIFT SHALL not affect the frame in progress.
REQ-024 tx SHALL be driven from a flop; no combinational path from inputs to tx or tx_done.

Reset
REQ-025 reset_n low SHALL immediately force tx=1, tx_done=0, busy=0, state IDLE, all counters and shift register 0/ones-padded idle value.
REQ-026 Reset mid-frame SHALL abort the frame without tx_done pulse; first load after release starts a fresh frame.
REQ-027 No output SHALL change on the release edge of reset_n itself.

Structure
REQ-028 Shared uart package SHALL hold FRAME_BITS, BAUD_W, the state enum, and the parity function.
REQ-029 One sub-module, uart_bit_timer, SHALL implement the bit-time counter with enable, latched k, and a one-cycle bit_tick output.
REQ-030 Shift register, bit counter and FSM SHALL reside in uart_tx_engine.

Verification
REQ-031 baud_k=4, eight=1, pen=0, data=8'h55 -> tx sequence 0,1,0,1,0,1,0,1,0,1,1, each 4 cycles; tx_done pulse 44 cycles after load; busy 44 cycles.
REQ-032 baud_k=2, eight=1, pen=1, ohel=0, data=8'h07 -> bit9 = 1 (even parity of three ones); ohel=1 -> bit9 = 0.
REQ-033 baud_k=3, eight=0, pen=1, ohel=0, data=8'hFF -> bit8 = parity of 7 ones = 1, bit9=1, bit10=1; data[7] never appears.
REQ-034 Load at cycle 0, second load at cycle 10 with baud_k=4 -> second ignored, single tx_done at cycle 44; load asserted in tx_done cycle -> new start bit next edge.
REQ-035 reset_n low at bit 5 of a frame -> tx=1, busy=0 asynchronously, no tx_done; load after release gives a complete correct frame.
REQ-036 baud_k=0, data=8'hA5, eight=1, pen=0 -> one cycle per bit, tx_done 11 cycles after load.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, divisor width, TX FSM states and
// the parity helper used when a frame is assembled.
package uart_pkg;

  localparam int UART_FRAME_BITS = 11;
  localparam int UART_BAUD_W     = 19;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  // XOR over the 7 or 8 active data bits; odd_sense inverts it for odd parity.
  function automatic logic parity_bit(input logic [7:0] d,
                                      input logic       eight,
                                      input logic       odd_sense);
    logic p;
    p = ^d[6:0];
    if (eight) p = p ^ d[7];
    return p ^ odd_sense;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time divisor: latches the cycles-per-bit on start and pulses bit_tick_o
// in the last cycle of every bit period while enabled.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BAUD_W = UART_BAUD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              en_i,
  input  logic [BAUD_W-1:0] k_i,
  output logic              bit_tick_o
);

  localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);

  logic [BAUD_W-1:0] k_q, k_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = en_i && (cnt_q == (k_q - ONE));

  always_comb begin
    k_d   = k_q;
    cnt_d = cnt_q;
    if (start_i) begin
      // A divisor of zero would never tick; treat it as one cycle per bit.
      k_d   = (k_i == '0) ? ONE : k_i;
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = bit_tick_o ? '0 : (cnt_q + ONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q   <= ONE;
      cnt_q <= '0;
    end else begin
      k_q   <= k_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: assembles an 11-bit frame on load and shifts it out
// LSB first, one bit per latched divisor period, with a done pulse at the end.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_W     = UART_BAUD_W,
  parameter int FRAME_BITS = UART_FRAME_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [7:0]        data,
  input  logic [BAUD_W-1:0] baud_k,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  output logic              tx,
  output logic              tx_done,
  output logic              busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  tx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  tx_done_q, tx_done_d;
  logic                  accept;
  logic                  bit_tick;
  logic                  par;
  logic [FRAME_BITS-1:0] frame;

  uart_bit_timer #(
    .BAUD_W (BAUD_W)
  ) u_bit_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (accept),
    .en_i       (state_q == SHIFT),
    .k_i        (baud_k),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    accept    = 1'b0;

    // Unused trailing positions stay at the stop/idle level.
    par        = parity_bit(data, eight, ohel);
    frame      = '1;
    frame[0]   = 1'b0;
    frame[7:1] = data[6:0];
    frame[8]   = eight ? data[7] : (pen ? par : 1'b1);
    frame[9]   = eight ? (pen ? par : 1'b1) : 1'b1;

    case (state_q)
      IDLE: begin
        if (load) begin
          accept    = 1'b1;
          state_d   = SHIFT;
          tx_d      = frame[0];
          shift_d   = {1'b1, frame[FRAME_BITS-1:1]};
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = IDLE;
            tx_d      = 1'b1;
            tx_done_d = 1'b1;
            shift_d   = '1;
            bit_cnt_d = '0;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;
  assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus predicts each accepted frame
// from the line rules, a monitor rebuilds frames from tx and compares them.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  data = '0;
  logic [18:0] baud_k = '0;
  logic        eight = 1'b0;
  logic        pen = 1'b0;
  logic        ohel = 1'b0;
  logic        tx, tx_done, busy;

  uart_tx_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .data    (data),
    .baud_k  (baud_k),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .tx      (tx),
    .tx_done (tx_done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] bits;
    int          k;
    int          edge_n;
    logic [7:0]  d;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic samples[$];
  int   cyc = 0;
  int   busy_until = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_frames = 0;
  bit   in_frame = 0;
  bit   wait_low = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line-level model: start bit, the active data bits LSB first, optional
  // parity, then stop level up to the fixed frame length.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e8,
                                              input logic pe, input logic odd);
    logic q[$];
    logic [10:0] f;
    int nbits, ones;
    nbits = e8 ? 8 : 7;
    ones  = 0;
    q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) q.push_back(((ones % 2) == 1) ^ odd);
    while (q.size() < 11) q.push_back(1'b1);
    for (int i = 0; i < 11; i++) f[i] = q[i];
    return f;
  endfunction

  task automatic scramble();
    data   = 8'($urandom);
    baud_k = 19'($urandom);
    eight  = 1'($urandom);
    pen    = 1'($urandom);
    ohel   = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      load = 1'b0;
      scramble();
    end
  endtask

  task automatic send(input logic [7:0] d, input int k, input logic e8,
                      input logic pe, input logic odd);
    int   n, keff;
    exp_t e;
    @(negedge clk);
    data = d; baud_k = 19'(k); eight = e8; pen = pe; ohel = odd; load = 1'b1;
    n    = cyc + 1;
    keff = (k == 0) ? 1 : k;
    if (n >= busy_until) begin
      e.bits = model_frame(d, e8, pe, odd);
      e.k = keff;
      e.edge_n = n;
      e.d = d;
      sb.push_back(e);
      busy_until = n + 11 * keff + 1;
    end
    @(negedge clk);
    load = 1'b0;
    scramble();
  endtask

  task automatic wait_free();
    while (cyc + 2 < busy_until) idle(1);
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      if (tx_done) check("done_in_reset", tx_done, 1'b0);
      in_frame = 0;
      wait_low = 0;
      samples.delete();
    end else if (in_frame) begin
      if (tx_done) begin
        int   len;
        logic [10:0] obs;
        logic stable;
        len = 11 * cur.k;
        check("frame_len", samples.size(), len);
        check("done_edge", cyc - cur.edge_n, len);
        check("tx_idle_at_done", tx, 1'b1);
        check("busy_clr_at_done", busy, 1'b0);
        obs = '0;
        stable = 1'b1;
        if (samples.size() == len) begin
          for (int b = 0; b < 11; b++) begin
            obs[b] = samples[b * cur.k];
            for (int j = 0; j < cur.k; j++)
              if (samples[b * cur.k + j] !== obs[b]) stable = 1'b0;
          end
          check("frame_bits", obs, cur.bits);
          check("bit_hold", stable, 1'b1);
        end
        n_frames++;
        $display("frame %0d: data=%02h k=%0d start_edge=%0d bits=%03h seen=%03h",
                 n_frames, cur.d, cur.k, cur.edge_n, cur.bits, obs);
        in_frame = 0;
      end else if (!busy) begin
        check("busy_dropped_early", busy, 1'b1);
        in_frame = 0;
      end else begin
        samples.push_back(tx);
        if (samples.size() > 11 * cur.k + 2) begin
          check("frame_overrun", samples.size(), 11 * cur.k);
          in_frame = 0;
          wait_low = 1;
        end
      end
    end else begin
      if (tx_done) check("spurious_done", tx_done, 1'b0);
      if (wait_low) begin
        if (!busy) wait_low = 0;
      end else if (busy) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", busy, 1'b0);
          wait_low = 1;
        end else begin
          cur = sb.pop_front();
          check("start_edge", cyc, cur.edge_n);
          samples.delete();
          samples.push_back(tx);
          in_frame = 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    reset_n = 1'b1;
    #1;
    check("release_tx", tx, 1'b1);
    idle(2);

    send(8'h55, 4, 1'b1, 1'b0, 1'b0); idle(50);
    send(8'h07, 2, 1'b1, 1'b1, 1'b0); idle(26);
    send(8'h07, 2, 1'b1, 1'b1, 1'b1); idle(26);
    send(8'hFF, 3, 1'b0, 1'b1, 1'b0); idle(38);
    send(8'hA5, 0, 1'b1, 1'b0, 1'b0); idle(15);

    // Load during a frame is dropped; a load in the done cycle is taken.
    send(8'h3C, 4, 1'b1, 1'b1, 1'b1);
    idle(8);
    send(8'hC3, 1, 1'b0, 1'b0, 1'b0);
    wait_free();
    send(8'h96, 2, 1'b0, 1'b1, 1'b1);
    wait_free();

    // Asynchronous reset around bit 5 aborts without a done pulse.
    send(8'h5A, 3, 1'b1, 1'b1, 1'b0);
    idle(16);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", tx_done, 1'b0);
    busy_until = 0;
    idle(2);
    reset_n = 1'b1;
    #1;
    check("rel_busy", busy, 1'b0);
    check("rel_tx", tx, 1'b1);
    send(8'h81, 3, 1'b1, 1'b1, 1'b1); idle(40);

    for (int i = 0; i < 40; i++) begin
      int mode, k;
      mode = $urandom_range(0, 2);
      k    = $urandom_range(0, 5);
      if (mode == 0) wait_free();
      else if (mode == 1) idle($urandom_range(0, 15));
      else idle($urandom_range(0, 3));
      send(8'($urandom), k, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 3000 && (sb.size() != 0 || in_frame); i++) idle(1);
    idle(3);
    check("scoreboard_drained", sb.size() + int'(in_frame), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
